spi_slave_gen2: RTL and testbench
=================================

// Module: spi_slave_gen2
// PURPOSE
//  Parametrised SPI slave front-end for the single-port RAM. Oversamples SS_n/MOSI on the system clock.
//  Deserialises 2-bit-command frames into rx_data with a one-cycle rx_valid pulse.
//  Serialises RAM read data from tx_data onto MISO.
//  Adds over previous generation: generic payload width, one-cycle rx_valid, tx_valid timeout, frame_err reporting.
// PARAMETERS
//  PAY_W       8   payload bits per frame (address or data); rx_data is PAY_W+2 bits
//  TX_TIMEOUT  15  max cycles waited in TX_WAIT for tx_valid; range 1..255
//  CNT_W       derived localparam $clog2(PAY_W+2), not user-settable
// PORTS
//  clk       in   1         system clock; all sampling on posedge
//  rst_n     in   1         asynchronous active-low reset
//  SS_n      in   1         slave select, active low; frame delimiter
//  MOSI      in   1         serial in, MSB first
//  MISO      out  1         serial out, MSB first, registered
//  rx_data   out  PAY_W+2   {cmd[1:0], payload[PAY_W-1:0]} to RAM
//  rx_valid  out  1         one-cycle strobe: rx_data complete
//  tx_data   in   PAY_W     read data from RAM
//  tx_valid  in   1         tx_data valid; sampled only in TX_WAIT
//  frame_err out  1         one-cycle strobe: aborted or illegal frame
//  addr_seen out  1         read address accepted, read-data frame pending
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE. MISO, rx_data, rx_valid, frame_err and addr_seen all 0. Counter and shift register 0.
//  Commands in rx_data[PAY_W+1:PAY_W]:
//   - 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
//  States: IDLE, CHK_CMD, RX, TX_WAIT, TX_SHIFT, DONE.
//  IDLE:
//   - SS_n low at cycle n -> CHK_CMD.
//  CHK_CMD (cycle n+1):
//   - MOSI -> rx_data[PAY_W+1].
//   - counter = PAY_W+1.
//   - -> RX.
//  RX:
//   - Shifts MOSI into the next lower bit for PAY_W+1 cycles (n+2 .. n+PAY_W+2).
//   - Then rx_valid=1 for exactly cycle n+PAY_W+3.
//   - Decode at completion:
//     - cmd 10: addr_seen<=1; -> DONE.
//     - cmd 11 with addr_seen=1: -> TX_WAIT, with rx_valid pulsed. The RAM ignores the payload.
//     - cmd 11 with addr_seen=0: no rx_valid; frame_err pulse; -> DONE.
//     - cmd 00/01: -> DONE.
//  TX_WAIT:
//   - On tx_valid: MISO <= tx_data[PAY_W-1]; shift register loads tx_data<<1; counter = PAY_W-1; -> TX_SHIFT.
//   - tx_valid and timeout in the same cycle: tx_valid wins.
//   - Timeout after TX_TIMEOUT cycles without tx_valid: frame_err pulse; addr_seen kept; -> DONE.
//  TX_SHIFT:
//   - MISO shifts out the remaining PAY_W-1 bits, one per cycle.
//   - MISO therefore carries PAY_W consecutive bits starting the cycle after tx_valid is sampled.
//   - Then addr_seen<=0; MISO<=0; -> DONE.
//  DONE:
//   - Holds until SS_n high, then IDLE.
//   - Extra MOSI bits are ignored; MISO=0.
//  SS_n high in CHK_CMD/RX/TX_WAIT/TX_SHIFT: next state IDLE; frame_err pulse; no rx_valid; MISO<=0; rx_data keeps partial bits.
//  rx_valid and frame_err never assert in the same cycle.
//  SS_n high in IDLE/DONE: silent return to IDLE.
//  A new frame may start the cycle after IDLE is re-entered. No minimum SS_n high time beyond one cycle.
//  rst_n asserted mid-frame: immediate reset values; addr_seen cleared.
// CONFIGURATION
//  SPI_SLAVE_PARITY_EN defined:
//   - RX frame gains one trailing odd-parity bit, sampled after bit 0 (rx_valid moves to n+PAY_W+4).
//   - Parity mismatch: frame_err instead of rx_valid; addr_seen not updated.
//   - TX appends odd parity over tx_data as bit PAY_W+1 on MISO.
//  Undefined: no parity bits; timing as above.
// STRUCTURE
//  Package spi_slave_pkg:
//   - state encoding, 3 bits: IDLE=000, CHK_CMD=001, RX=010, TX_WAIT=011, TX_SHIFT=100, DONE=101.
//   - command codes CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA.
//  Sub-module spi_tx_serializer: load/shift register plus MISO register and bit counter, PAY_W parameter.
// TESTING (PAY_W=8 unless noted)
//  1. WR_ADDR frame 00_1010_0101 -> rx_data=0x0A5, rx_valid high exactly one cycle at n+11; frame_err=0.
//  2. RD_ADDR 10_0000_0011, then RD_DATA 11_xxxx_xxxx with tx_valid+tx_data=0xC3 three cycles later
//     -> MISO 1,1,0,0,0,0,1,1; addr_seen 1 -> 0.
//  3. RD_DATA with addr_seen=0 -> no rx_valid, frame_err one pulse, MISO stays 0.
//  4. SS_n raised after 5 payload bits -> frame_err pulse, state IDLE, no rx_valid; next full frame accepted.
//  5. RD_DATA, tx_valid withheld -> frame_err at TX_TIMEOUT, addr_seen still 1; rst_n low mid-TX -> all outputs 0 at once.
//  6. PAY_W=16 with SPI_SLAVE_PARITY_EN: WR_DATA 0xBEEF, correct parity -> rx_valid; flipped parity -> frame_err only.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for spi_slave_gen2: FSM state encoding, command codes
// and the odd-parity helper used by the optional parity build.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_CHK_CMD  = 3'b001,
        ST_RX       = 3'b010,
        ST_TX_WAIT  = 3'b011,
        ST_TX_SHIFT = 3'b100,
        ST_DONE     = 3'b101
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Bit that makes the total number of ones (vector plus this bit) odd.
    function automatic logic odd_parity(input logic [63:0] vec);
        return ~(^vec);
    endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO serializer: parallel load, MSB-first shift, registered MISO and a
// remaining-bit counter whose zero state marks the last bit on the line.
module spi_tx_serializer #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [NBITS-1:0] load_data,
    output logic             miso,
    output logic             last
);
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] CW_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [NBITS-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;

    // Shift register, MISO bit and remaining-bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso    <= 1'b0;
            shreg_r <= '0;
            cnt_r   <= '0;
        end else if (clr) begin
            miso    <= 1'b0;
            shreg_r <= '0;
            cnt_r   <= '0;
        end else if (load) begin
            miso    <= load_data[NBITS-1];
            shreg_r <= load_data << 1'b1;
            cnt_r   <= CW'(NBITS - 1);
        end else if (shift) begin
            miso    <= shreg_r[NBITS-1];
            shreg_r <= shreg_r << 1'b1;
            cnt_r   <= cnt_r - CW_ONE;
        end
    end

    assign last = (cnt_r == '0);

endmodule

// File: rtl/spi_slave_gen2.sv
// SPI slave front-end for the single-port RAM, oversampled on clk.
// Optional feature macro: SPI_SLAVE_PARITY_EN (odd parity on RX frame and TX word).
module spi_slave_gen2
    import spi_slave_pkg::*;
#(
    parameter int PAY_W      = 8,
    parameter int TX_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             MOSI,
    output logic             MISO,
    output logic [PAY_W+1:0] rx_data,
    output logic             rx_valid,
    input  logic [PAY_W-1:0] tx_data,
    input  logic             tx_valid,
    output logic             frame_err,
    output logic             addr_seen
);
    localparam int CNT_W = $clog2(PAY_W + 2);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef SPI_SLAVE_PARITY_EN
    localparam int TX_BITS = PAY_W + 1;
`else
    localparam int TX_BITS = PAY_W;
`endif

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, bit_idx_s;
    logic [7:0]         wait_r, wait_s;
    logic               bit_wr_s, rx_valid_s, frame_err_s;
    logic               addr_set_s, addr_clr_s;
    logic               frame_end_s, par_ok_s;
    logic               tx_load_s, tx_shift_s, tx_clr_s, tx_last_s;
    logic [TX_BITS-1:0] tx_word_s;

`ifdef SPI_SLAVE_PARITY_EN
    assign tx_word_s = {tx_data, odd_parity(64'(tx_data))};
`else
    assign tx_word_s = tx_data;
`endif

    spi_tx_serializer #(.NBITS(TX_BITS)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tx_clr_s),
        .load      (tx_load_s),
        .shift     (tx_shift_s),
        .load_data (tx_word_s),
        .miso      (MISO),
        .last      (tx_last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        wait_s      = wait_r;
        bit_wr_s    = 1'b0;
        bit_idx_s   = '0;
        rx_valid_s  = 1'b0;
        frame_err_s = 1'b0;
        addr_set_s  = 1'b0;
        addr_clr_s  = 1'b0;
        frame_end_s = 1'b0;
        par_ok_s    = 1'b1;
        tx_load_s   = 1'b0;
        tx_shift_s  = 1'b0;
        tx_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!SS_n) begin
                    state_s = ST_CHK_CMD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHK_CMD: begin
                if (SS_n) begin
                    state_s     = ST_IDLE;
                    frame_err_s = 1'b1;
                    tx_clr_s    = 1'b1;
                end else begin
                    bit_wr_s  = 1'b1;
                    bit_idx_s = CNT_W'(PAY_W + 1);
                    cnt_s     = CNT_W'(PAY_W + 1);
                    state_s   = ST_RX;
                end
            end
            ST_RX: begin
                if (SS_n) begin
                    state_s     = ST_IDLE;
                    frame_err_s = 1'b1;
                    tx_clr_s    = 1'b1;
                end else begin
                    if (cnt_r != '0) begin
                        bit_wr_s  = 1'b1;
                        bit_idx_s = cnt_r - CNT_ONE;
                        cnt_s     = cnt_r - CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
`ifdef SPI_SLAVE_PARITY_EN
                    // Counter at zero: the bit on MOSI now is the trailing parity bit.
                    frame_end_s = (cnt_r == '0);
                    par_ok_s    = (MOSI == odd_parity(64'(rx_data)));
`else
                    frame_end_s = (cnt_r == CNT_ONE);
                    par_ok_s    = 1'b1;
`endif
                    if (frame_end_s) begin
                        state_s = ST_DONE;
                        if (!par_ok_s) begin
                            frame_err_s = 1'b1;
                        end else begin
                            case (rx_data[PAY_W+1:PAY_W])
                                CMD_RD_ADDR: begin
                                    rx_valid_s = 1'b1;
                                    addr_set_s = 1'b1;
                                end
                                CMD_RD_DATA: begin
                                    if (addr_seen) begin
                                        rx_valid_s = 1'b1;
                                        wait_s     = '0;
                                        state_s    = ST_TX_WAIT;
                                    end else begin
                                        frame_err_s = 1'b1;
                                    end
                                end
                                default: begin
                                    rx_valid_s = 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        state_s = ST_RX;
                    end
                end
            end
            ST_TX_WAIT: begin
                if (SS_n) begin
                    state_s     = ST_IDLE;
                    frame_err_s = 1'b1;
                    tx_clr_s    = 1'b1;
                end else if (tx_valid) begin
                    tx_load_s = 1'b1;
                    state_s   = ST_TX_SHIFT;
                end else if (wait_r == 8'(TX_TIMEOUT - 1)) begin
                    frame_err_s = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    wait_s = wait_r + 8'd1;
                end
            end
            ST_TX_SHIFT: begin
                if (SS_n) begin
                    state_s     = ST_IDLE;
                    frame_err_s = 1'b1;
                    tx_clr_s    = 1'b1;
                end else if (tx_last_s) begin
                    tx_clr_s   = 1'b1;
                    addr_clr_s = 1'b1;
                    state_s    = ST_DONE;
                end else begin
                    tx_shift_s = 1'b1;
                end
            end
            ST_DONE: begin
                if (SS_n) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                tx_clr_s = 1'b1;
            end
        endcase
    end

    // Receive shift register, counters and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            cnt_r     <= '0;
            wait_r    <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            addr_seen <= 1'b0;
        end else begin
            if (bit_wr_s) begin
                rx_data[bit_idx_s] <= MOSI;
            end
            cnt_r     <= cnt_s;
            wait_r    <= wait_s;
            rx_valid  <= rx_valid_s;
            frame_err <= frame_err_s;
            if (addr_set_s) begin
                addr_seen <= 1'b1;
            end else if (addr_clr_s) begin
                addr_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Randomized bench for spi_slave_gen2: frames are built as bit lists and the
// expected strobes, RX word and MISO stream come from a frame-level model.
module tb_spi_slave_gen2;
`ifdef SPI_SLAVE_PARITY_EN
    localparam int PAY_W = 16;
    localparam bit PAR   = 1'b1;
`else
    localparam int PAY_W = 8;
    localparam bit PAR   = 1'b0;
`endif
    localparam int TX_TIMEOUT = 15;
    localparam int TXB        = PAY_W + (PAR ? 1 : 0);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             SS_n = 1'b1;
    logic             MOSI = 1'b0;
    logic             MISO;
    logic [PAY_W+1:0] rx_data;
    logic             rx_valid;
    logic [PAY_W-1:0] tx_data = '0;
    logic             tx_valid = 1'b0;
    logic             frame_err;
    logic             addr_seen;

    int n_vec = 0;
    int n_err = 0;
    bit addr_m = 1'b0;

    spi_slave_gen2 #(.PAY_W(PAY_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .frame_err (frame_err),
        .addr_seen (addr_seen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SPI frame plus its optional read-data phase; expectations come from addr_m and the frame rules.
    task automatic run_frame(input logic [1:0] cmd, input logic [PAY_W-1:0] pay, input int abort_at,
                             input bit bad_par, input int delay, input logic [PAY_W-1:0] word,
                             input int rst_at);
        bit               q[$];
        bit               txq[$];
        logic [PAY_W+1:0] frame;
        bit               accept;
        bit               want_tx;
        frame = {cmd, pay};
        for (int i = PAY_W + 1; i >= 0; i--) q.push_back(frame[i]);
        if (PAR) q.push_back(($countones(frame) % 2 == 0) ^ bad_par);

        SS_n = 1'b0;
        MOSI = 1'($urandom_range(0, 1));
        tick();
        check_eq("start_quiet", 64'({rx_valid, frame_err}), 64'd0);
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_at) begin
                SS_n = 1'b1;
                tx_valid = 1'b0;
                tick();
                check_eq("abort_strobe", 64'({rx_valid, frame_err, MISO}), 64'b010);
                tick();
                check_eq("abort_clear", 64'({rx_valid, frame_err}), 64'd0);
                check_eq("abort_addr", 64'(addr_seen), 64'(addr_m));
                return;
            end
            MOSI = q[i];
            tx_valid = 1'($urandom_range(0, 1));
            tick();
            if (i < q.size() - 1) check_eq("rx_quiet", 64'({rx_valid, frame_err}), 64'd0);
        end
        tx_valid = 1'b0;

        accept  = !bad_par && !(cmd == 2'b11 && !addr_m);
        want_tx = accept && cmd == 2'b11;
        check_eq("rx_strobe", 64'({rx_valid, frame_err}), accept ? 64'b10 : 64'b01);
        if (accept) check_eq("rx_data", 64'(rx_data), 64'(frame));
        if (accept && cmd == 2'b10) addr_m = 1'b1;

        if (want_tx) begin
            for (int j = 1; j <= delay && j <= TX_TIMEOUT; j++) begin
                MOSI = 1'($urandom_range(0, 1));
                tick();
                check_eq("wait_err", 64'({rx_valid, frame_err}), (j == TX_TIMEOUT) ? 64'b01 : 64'b00);
                check_eq("wait_miso", 64'(MISO), 64'd0);
            end
            if (delay < TX_TIMEOUT) begin
                for (int i = PAY_W - 1; i >= 0; i--) txq.push_back(word[i]);
                if (PAR) txq.push_back($countones(word) % 2 == 0);
                tx_valid = 1'b1;
                tx_data  = word;
                tick();
                tx_valid = 1'b0;
                tx_data  = PAY_W'($urandom);
                check_eq("miso_bit0", 64'({MISO, rx_valid, frame_err}), 64'({txq[0], 2'b00}));
                for (int k = 1; k < TXB; k++) begin
                    if (k == rst_at) begin
                        #2 rst_n = 1'b0;
                        #1;
                        check_eq("rst_outputs", 64'({MISO, rx_valid, frame_err, addr_seen}), 64'd0);
                        check_eq("rst_rx_data", 64'(rx_data), 64'd0);
                        tick();
                        SS_n = 1'b1;
                        tick();
                        rst_n  = 1'b1;
                        addr_m = 1'b0;
                        tick();
                        check_eq("rst_idle", 64'({MISO, frame_err, addr_seen}), 64'd0);
                        return;
                    end
                    tick();
                    check_eq("miso_bit", 64'(MISO), 64'(txq[k]));
                    check_eq("addr_hold", 64'(addr_seen), 64'd1);
                end
                tick();
                check_eq("tx_end", 64'({MISO, addr_seen}), 64'd0);
                addr_m = 1'b0;
            end
        end

        MOSI = 1'($urandom_range(0, 1));
        tick();
        check_eq("done_hold", 64'({MISO, rx_valid, frame_err}), 64'd0);
        SS_n = 1'b1;
        tick();
        check_eq("idle_quiet", 64'({MISO, rx_valid, frame_err}), 64'd0);
        check_eq("addr_seen", 64'(addr_seen), 64'(addr_m));
    endtask

    initial begin
        logic [1:0]       rcmd;
        logic [PAY_W-1:0] rpay;
        logic [PAY_W-1:0] rword;
        int               rabort;
        bit               rbad;
        tick();
        tick();
        check_eq("reset_outputs", 64'({MISO, rx_valid, frame_err, addr_seen}), 64'd0);
        check_eq("reset_rx_data", 64'(rx_data), 64'd0);
        rst_n = 1'b1;
        tick();

        run_frame(2'b00, PAY_W'(8'hA5), -1, 1'b0, 0, '0, -1);
        run_frame(2'b11, PAY_W'(8'h5A), -1, 1'b0, 0, '0, -1);
        run_frame(2'b10, PAY_W'(8'h03), -1, 1'b0, 0, '0, -1);
        run_frame(2'b11, PAY_W'(8'h77), -1, 1'b0, 3, PAY_W'(8'hC3), -1);
        run_frame(2'b01, PAY_W'(8'h3C), 7, 1'b0, 0, '0, -1);
        run_frame(2'b01, PAY_W'(8'h3C), -1, 1'b0, 0, '0, -1);
        run_frame(2'b10, PAY_W'(8'h10), -1, 1'b0, 0, '0, -1);
        run_frame(2'b11, PAY_W'(8'h00), -1, 1'b0, TX_TIMEOUT + 1, PAY_W'(8'hFF), -1);
        run_frame(2'b11, PAY_W'(8'h00), -1, 1'b0, TX_TIMEOUT - 1, PAY_W'(8'h81), -1);
        run_frame(2'b10, PAY_W'(8'h20), -1, 1'b0, 0, '0, -1);
        run_frame(2'b11, PAY_W'(8'h00), -1, 1'b0, 0, PAY_W'(8'hE7), 3);
`ifdef SPI_SLAVE_PARITY_EN
        run_frame(2'b01, PAY_W'(16'hBEEF), -1, 1'b0, 0, '0, -1);
        run_frame(2'b01, PAY_W'(16'hBEEF), -1, 1'b1, 0, '0, -1);
        run_frame(2'b10, PAY_W'(16'h1234), -1, 1'b1, 0, '0, -1);
        run_frame(2'b11, PAY_W'(16'h0000), -1, 1'b0, 0, PAY_W'(16'hA5A5), -1);
`endif

        for (int n = 0; n < 80; n++) begin
            rcmd   = 2'($urandom_range(0, 3));
            rpay   = PAY_W'($urandom);
            rword  = PAY_W'($urandom);
            rabort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, PAY_W + 1 + (PAR ? 1 : 0))) : -1;
            rbad   = PAR && ($urandom_range(0, 4) == 0);
            run_frame(rcmd, rpay, rabort, rbad, int'($urandom_range(0, TX_TIMEOUT + 2)), rword, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
